mux_1: RTL and testbench

Registered 4-to-1 selector. One of four data inputs (a, b, c, d) is chosen by a 2-bit select s and driven on o. It is a leaf datapath primitive used wherever a clocked, reset-clean one-of-four choice is needed. The default configuration is 1-bit wide with a one-cycle output register.

---
 rtl/mux_1_pkg.sv | 13 +
 rtl/mux_1_core.sv | 26 ++
 rtl/mux_1.sv | 79 +++++++
 tb/tb_mux_1.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_1_pkg.sv
// Shared definitions for the mux_1 registered 4-to-1 selector.
//   sel_t           : 2-bit select type
//   SEL_A .. SEL_D  : select encodings choosing inputs a .. d
package mux_1_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_A = 2'b00;
    localparam sel_t SEL_B = 2'b01;
    localparam sel_t SEL_C = 2'b10;
    localparam sel_t SEL_D = 2'b11;

endpackage : mux_1_pkg

// File: rtl/mux_1_core.sv
// Purely combinational WIDTH-bit 4:1 selector.
// Ports:
//   a, b, c, d : WIDTH-bit data inputs (chosen by s = 00, 01, 10, 11)
//   s          : 2-bit select
//   y          : WIDTH-bit selected data
module mux_1_core
    import mux_1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  sel_t             s,
    output logic [WIDTH-1:0] y
);

    // Full-case selection with no priority. Written as a balanced ternary
    // tree so an X/Z select propagates X to y in simulation.
    always_comb begin
        y = s[1] ? (s[0] ? d : c)
                 : (s[0] ? b : a);
    end

endmodule : mux_1_core

// File: rtl/mux_1.sv
// Registered 4-to-1 selector.
// Parameters:
//   WIDTH   : data width of a/b/c/d/o (1..64)
//   REG_OUT : 1 = o registered with one cycle of latency,
//             0 = o follows the selected input combinationally
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   a..d     : data inputs, selected by s = 00/01/10/11
//   s        : select
//   in_valid : qualifies s and a..d for capture
//   o        : selected data
//   o_valid  : o holds data captured from a valid cycle
//
// Handshake: valid-only, there is no ready. A beat is transferred on every
// rising clk where in_valid=1; the result appears on o with o_valid=1 one
// cycle later (REG_OUT=1). When in_valid=0 o keeps its last value and
// o_valid drops for that cycle.
module mux_1
    import mux_1_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  sel_t             s,
    input  logic             in_valid,
    output logic [WIDTH-1:0] o,
    output logic             o_valid
);

    logic [WIDTH-1:0] sel_data;

    mux_1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a (a),
        .b (b),
        .c (c),
        .d (d),
        .s (s),
        .y (sel_data)
    );

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] o_q;
            logic             valid_q;

            // Reset clears both immediately and wins over a coincident edge;
            // data only advances on valid beats, valid tracks in_valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_q     <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= in_valid;
                    if (in_valid) begin
                        o_q <= sel_data;
                    end
                end
            end

            assign o       = o_q;
            assign o_valid = valid_q;
        end else begin : g_comb
            // Data path ignores reset and in_valid entirely; only the
            // qualifier sees reset. clk is not used in this configuration.
            assign o       = sel_data;
            assign o_valid = in_valid & rst_n;
        end
    endgenerate

endmodule : mux_1

// File: tb/tb_mux_1.sv
// Self-checking bench for mux_1: a registered 1-bit instance fed through a
// scoreboard queue, plus a combinational 8-bit instance checked directly.
module tb_mux_1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- registered 1-bit DUT ----------------
    logic       a, b, c, d;
    logic [1:0] s;
    logic       in_valid;
    logic       o;
    logic       o_valid;

    mux_1 #(
        .WIDTH   (1),
        .REG_OUT (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .s        (s),
        .in_valid (in_valid),
        .o        (o),
        .o_valid  (o_valid)
    );

    // ---------------- combinational 8-bit DUT ----------------
    logic [7:0] ca, cb, cc, cd;
    logic [1:0] cs;
    logic       c_in_valid;
    logic [7:0] c_o;
    logic       c_o_valid;

    mux_1 #(
        .WIDTH   (8),
        .REG_OUT (1'b0)
    ) dut_comb (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (ca),
        .b        (cb),
        .c        (cc),
        .d        (cd),
        .s        (cs),
        .in_valid (c_in_valid),
        .o        (c_o),
        .o_valid  (c_o_valid)
    );

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual,
                     expected, $time);
        end
    endtask

    // Monitor: every valid output beat must match the oldest expectation.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_valid: got o=%0h with empty queue at %0t",
                         o, $time);
            end else begin
                check("scoreboard_o", {63'd0, o}, {63'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply(input logic va, input logic vb, input logic vc,
                         input logic vd, input logic [1:0] vs,
                         input logic exp_o);
        @(posedge clk);
        #1;
        a = va; b = vb; c = vc; d = vd; s = vs;
        in_valid = 1'b1;
        exp_q.push_back(exp_o);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Directed vectors: {a, b, c, d, s, expected o}
    logic [6:0] sel_vec [4] = '{
        {4'b1101, 2'b00, 1'b1},
        {4'b0101, 2'b01, 1'b1},
        {4'b1010, 2'b10, 1'b1},
        {4'b0101, 2'b11, 1'b1}
    };

    // Isolation sweep: one-hot {a,b,c,d}, swept s, expected o per s.
    logic [3:0] iso_in  [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [3:0] iso_exp [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    // ---------------- main stimulus ----------------
    initial begin
        rst_n = 1'b0;
        a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0; s = 2'b00;
        in_valid = 1'b0;
        ca = 8'h00; cb = 8'h00; cc = 8'h00; cd = 8'h00; cs = 2'b00;
        c_in_valid = 1'b0;

        // 1. Reset held with valid, toggling inputs: outputs stay clear.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            a = 1'b1; b = 1'b1; c = 1'b1; d = 1'b1;
            s = 2'(i);
            in_valid = 1'b1;
            @(negedge clk);
            check("reset_o", {63'd0, o}, 64'd0);
            check("reset_o_valid", {63'd0, o_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("release_no_capture", {63'd0, o_valid}, 64'd0);

        // First capture after release, then each select.
        for (int i = 0; i < 4; i++) begin
            apply(sel_vec[i][6], sel_vec[i][5], sel_vec[i][4], sel_vec[i][3],
                  sel_vec[i][2:1], sel_vec[i][0]);
        end

        // 3. Isolation sweeps, back to back.
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                apply(iso_in[k][3], iso_in[k][2], iso_in[k][1], iso_in[k][0],
                      2'(j), iso_exp[k][3-j]);
            end
        end
        idle();

        // 4. Valid gating: capture 1, then drop valid and clear the input.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("gate_hold_o", {63'd0, o}, 64'd1);
        check("gate_o_valid", {63'd0, o_valid}, 64'd0);

        // 6. Combinational instance: same-cycle response, no clock edge.
        ca = 8'hA5; cb = 8'h3C; cc = 8'hFF; cd = 8'h00; cs = 2'b10;
        c_in_valid = 1'b1;
        #1;
        check("comb_sel_c", {56'd0, c_o}, 64'h0000_0000_0000_00FF);
        check("comb_o_valid", {63'd0, c_o_valid}, 64'd1);
        cs = 2'b01;
        #1;
        check("comb_sel_b", {56'd0, c_o}, 64'h0000_0000_0000_003C);

        // 5. Async reset between edges while o=1.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_o", {63'd0, o}, 64'd0);
        check("async_o_valid", {63'd0, o_valid}, 64'd0);
        check("comb_o_in_reset", {56'd0, c_o}, 64'h0000_0000_0000_003C);
        check("comb_valid_in_reset", {63'd0, c_o_valid}, 64'd0);
        #2;
        rst_n = 1'b1;
        c_in_valid = 1'b0;
        #1;
        check("comb_valid_low", {63'd0, c_o_valid}, 64'd0);

        // One more capture after recovery.
        apply(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
        idle();

        // Drain with a bounded wait.
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
            @(negedge clk);
        end
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global time limit.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_mux_1
